// File: rtl/usbd_pkg.sv
// Shared USB device-side definitions: PID codes, responder state encoding,
// CRC constants and the token CRC5 helper.
package usbd_pkg;

    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [4:0]  CRC5_INIT       = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL   = 5'h0C;
    localparam logic [4:0]  CRC5_POLY       = 5'h05;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SKIP,
        ST_TOK1,
        ST_TOK2,
        ST_TOKEOP,
        ST_NAK,
        ST_TXPID,
        ST_TXDATA,
        ST_TXCRC0,
        ST_TXCRC1,
        ST_WAITHS
    } state_t;

    // Token CRC5 over {endp, addr}, address LSB first on the wire. The result is
    // already complemented and bit-ordered as it sits in token byte 2 bits [7:3].
    function automatic logic [4:0] crc5_field(input logic [10:0] bits);
        logic [4:0] c;
        logic       fb;
        c = CRC5_INIT;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ bits[i];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ CRC5_POLY;
        end
        c = ~c;
        return {c[0], c[1], c[2], c[3], c[4]};
    endfunction

endpackage

// File: rtl/usbd_crc16.sv
// Byte-wide USB CRC16 register (reflected 0x8005, init 0xFFFF). The output is
// the raw register; the transmitter sends its complement.
module usbd_crc16
    import usbd_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_q ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC16_POLY_REFL) : (crc_next >> 1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_q <= CRC16_INIT;
        end else if (clear) begin
            crc_q <= CRC16_INIT;
        end else if (en) begin
            crc_q <= crc_next;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usbd_hid_report_responder.sv
// USB HID interrupt-IN responder: answers IN tokens with DATA0/1 + report + CRC16
// or NAK, and retransmits until ACKed. Define USBD_CRC5_CHECK_EN to verify token CRC5.
module usbd_hid_report_responder
    import usbd_pkg::*;
#(
    parameter int C_report_bytes = 8,
    parameter int C_endpoint     = 1,
    parameter int C_hs_timeout   = 400
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [6:0]                  dev_addr,
    input  logic [C_report_bytes*8-1:0] report,
    input  logic                        report_valid,
    output logic                        report_ready,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        rx_eop,
    input  logic                        rx_err,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    output logic                        tx_last,
    input  logic                        tx_ready,
    output logic                        toggle,
    output logic                        report_sent
);

    localparam int IDX_W = (C_report_bytes > 1) ? $clog2(C_report_bytes) : 1;
    localparam int TMR_W = (C_hs_timeout > 0) ? $clog2(C_hs_timeout + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_report_bytes - 1);
    localparam logic [TMR_W-1:0] HS_LOAD  = TMR_W'(C_hs_timeout);
    localparam logic [3:0]       ENDP     = 4'(C_endpoint);

    state_t                      state_q, state_d;
    logic [7:0]                  tok_b1_q, tok_b2_q;
    logic [IDX_W-1:0]            byte_idx_q;
    logic [TMR_W-1:0]            hs_timer_q;
    logic                        toggle_q;
    logic                        pending_q;
    logic                        report_sent_q;
    logic [C_report_bytes*8-1:0] report_buf_q;
    logic [15:0]                 crc;

    logic crc_clear, crc_en, hs_load;
    logic latch_b1, latch_b2, ack_seen;
    logic load_report, receiving;
    logic hit_now, hit_held;

    function automatic logic token_match(input logic [7:0] b1, input logic [7:0] b2,
                                         input logic [6:0] addr);
        logic hit;
        hit = (b1[6:0] == addr) && ({b2[2:0], b1[7]} == ENDP);
`ifdef USBD_CRC5_CHECK_EN
        hit = hit && (b2[7:3] == crc5_field({b2[2:0], b1}));
`endif
        return hit;
    endfunction

    function automatic state_t token_verdict(input logic hit, input logic pend);
        if (!hit) return ST_IDLE;
        return pend ? ST_TXPID : ST_NAK;
    endfunction

    // The last token byte may arrive together with rx_eop, so match it straight off rx_data too.
    assign hit_now     = token_match(tok_b1_q, rx_data, dev_addr);
    assign hit_held    = token_match(tok_b1_q, tok_b2_q, dev_addr);
    assign receiving   = !(state_q inside {ST_NAK, ST_TXPID, ST_TXDATA, ST_TXCRC0, ST_TXCRC1});
    assign load_report = report_valid && report_ready;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_d      = state_q;
        tx_valid     = 1'b0;
        tx_last      = 1'b0;
        tx_data      = 8'h00;
        report_ready = 1'b0;
        crc_clear    = 1'b0;
        crc_en       = 1'b0;
        hs_load      = 1'b0;
        latch_b1     = 1'b0;
        latch_b2     = 1'b0;
        ack_seen     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                report_ready = 1'b1;
                if (rx_valid && !rx_eop) state_d = (rx_data == PID_IN) ? ST_TOK1 : ST_SKIP;
            end
            ST_SKIP: begin
                report_ready = 1'b1;
                if (rx_eop) state_d = ST_IDLE;
            end
            ST_TOK1: begin
                report_ready = 1'b1;
                if (rx_eop) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    latch_b1 = 1'b1;
                    state_d  = ST_TOK2;
                end
            end
            ST_TOK2: begin
                report_ready = 1'b1;
                if (rx_valid) begin
                    latch_b2 = 1'b1;
                    state_d  = rx_eop ? token_verdict(hit_now, pending_q) : ST_TOKEOP;
                end else if (rx_eop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TOKEOP: begin
                report_ready = 1'b1;
                if (rx_eop) begin
                    state_d = rx_valid ? ST_IDLE : token_verdict(hit_held, pending_q);
                end else if (rx_valid) begin
                    state_d = ST_SKIP;
                end
            end
            ST_NAK: begin
                report_ready = 1'b1;
                tx_valid     = 1'b1;
                tx_last      = 1'b1;
                tx_data      = PID_NAK;
                if (tx_ready) state_d = ST_IDLE;
            end
            ST_TXPID: begin
                tx_valid  = 1'b1;
                tx_data   = toggle_q ? PID_DATA1 : PID_DATA0;
                crc_clear = 1'b1;
                if (tx_ready) state_d = ST_TXDATA;
            end
            ST_TXDATA: begin
                tx_valid = 1'b1;
                tx_data  = report_buf_q[byte_idx_q*8 +: 8];
                crc_en   = tx_ready;
                if (tx_ready && (byte_idx_q == LAST_IDX)) state_d = ST_TXCRC0;
            end
            ST_TXCRC0: begin
                tx_valid = 1'b1;
                tx_data  = ~crc[7:0];
                if (tx_ready) state_d = ST_TXCRC1;
            end
            ST_TXCRC1: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = ~crc[15:8];
                if (tx_ready) begin
                    hs_load = 1'b1;
                    state_d = ST_WAITHS;
                end
            end
            ST_WAITHS: begin
                if (rx_valid) begin
                    ack_seen = (rx_data == PID_ACK);
                    state_d  = ST_IDLE;
                end else if (hs_timer_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A PHY error drops whatever packet was being received, including a handshake.
        if (rx_err && receiving) begin
            state_d  = ST_IDLE;
            ack_seen = 1'b0;
            latch_b1 = 1'b0;
            latch_b2 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            tok_b1_q      <= 8'h00;
            tok_b2_q      <= 8'h00;
            byte_idx_q    <= '0;
            hs_timer_q    <= '0;
            toggle_q      <= 1'b0;
            pending_q     <= 1'b0;
            report_sent_q <= 1'b0;
        end else begin
            // NOTE: state uses <= so every flop here samples the pre-edge values.
            state_q       <= state_d;
            report_sent_q <= ack_seen;
            if (latch_b1) tok_b1_q <= rx_data;
            if (latch_b2) tok_b2_q <= rx_data;

            if (crc_clear) begin
                byte_idx_q <= '0;
            end else if (crc_en) begin
                byte_idx_q <= byte_idx_q + 1'b1;
            end

            if (hs_load) begin
                hs_timer_q <= HS_LOAD;
            end else if ((state_q == ST_WAITHS) && (hs_timer_q != '0)) begin
                hs_timer_q <= hs_timer_q - 1'b1;
            end

            // An unacknowledged report stays pending with the same toggle for retransmission.
            if (ack_seen) begin
                toggle_q  <= ~toggle_q;
                pending_q <= 1'b0;
            end else if (load_report) begin
                pending_q <= 1'b1;
            end
        end
    end

    // NOTE: the report buffer is pure data qualified by pending_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_report) report_buf_q <= report;
    end

    usbd_crc16 u_crc16 (
        .clk    (clk),
        .resetn (resetn),
        .clear  (crc_clear),
        .en     (crc_en),
        .data   (tx_data),
        .crc    (crc)
    );

    assign toggle      = toggle_q;
    assign report_sent = report_sent_q;

endmodule

// File: doc/usbd_hid_report_responder.md
Name: usbd_hid_report_responder

Overview:
- Device-side USB HID interrupt-IN responder, byte-level; the peer of our usbh_host_hid report poller.
- Consumes decoded token and handshake packets from a byte-level USB PHY/deserializer.
- Answers IN tokens addressed to its address and endpoint with DATA0/DATA1 + report + CRC16, or with NAK when no report is pending.
- Tracks the data toggle and retransmits when the host does not ACK.

Parameters:
C_report_bytes, 8, HID report length in bytes (>=1)
C_endpoint, 1, interrupt IN endpoint number (1..15)
C_hs_timeout, 400, clk cycles to wait for a host handshake after the last TX byte

Ports:
clk  in  1  system clock (6 or 48 MHz domain)
resetn  in  1  asynchronous active-low reset
dev_addr  in  7  assigned device address, sampled at token check
report  in  C_report_bytes*8  new report, byte 0 in [7:0]
report_valid  in  1  load report; accepted only while report_ready=1
report_ready  out  1  buffer not in use by a transmission
rx_data  in  8  received packet byte, PID byte first
rx_valid  in  1  rx_data valid this cycle
rx_eop  in  1  end of packet; may coincide with the last rx_valid
rx_err  in  1  PHY error (bitstuff/sync); aborts the current packet
tx_data  out  8  byte to send
tx_valid  out  1  tx_data valid
tx_last  out  1  final byte of the packet
tx_ready  in  1  PHY accepts tx_data this cycle
toggle  out  1  current data toggle (0=DATA0)
report_sent  out  1  one-cycle pulse when an ACK is received for a report

Behaviour:
- Reset values: tx_valid=0, tx_last=0, tx_data=0, toggle=0, report_sent=0, report_ready=1, pending=0, state=IDLE.
- PIDs:
  - IN = 0x69, ACK = 0xD2, NAK = 0x5A, DATA0 = 0xC3, DATA1 = 0x4B.
  - A PID byte whose high nibble is not the complement of its low nibble is ignored (state goes to SKIP).
- IDLE:
  - rx_valid with 0x69 -> TOK1.
  - Any other PID -> SKIP.
- SKIP: wait for rx_eop -> IDLE.
- TOK1: rx_valid -> latch byte1 -> TOK2.
- TOK2: rx_valid -> latch byte2 -> TOKEOP.
- TOKEOP: at rx_eop, check the token:
  - Match requires byte1[6:0]==dev_addr and {byte2[2:0],byte1[7]}==C_endpoint.
  - Match with pending=1 -> TXPID.
  - Match with pending=0 -> NAK.
  - Mismatch -> IDLE.
  - rx_eop before 3 bytes -> IDLE.
- Any state: rx_err while receiving -> IDLE, no response.
- NAK: present 0x5A with tx_last=1, hold until tx_ready -> IDLE.
- TXPID: present DATA0 or DATA1 per toggle -> TXDATA.
- TXDATA: C_report_bytes bytes, byte 0 first.
- TXCRC0, TXCRC1: CRC16 low byte then high byte; tx_last=1 on the high byte.
- CRC16 rule:
  - Polynomial 0x8005, reflected, init 0xFFFF, output complemented.
  - Covers the data bytes only, not the PID.
- TX handshake:
  - tx_valid stays high and tx_data stable until tx_ready; one byte advances per accepted cycle.
  - TX states never consume rx bytes.
- WAITHS: after the last byte is accepted, the timeout counter loads C_hs_timeout.
  - Received ACK packet -> toggle flips, pending=0, report_sent pulses 1 cycle -> IDLE.
  - Timeout expiry, any other PID, or rx_err -> IDLE with toggle and pending unchanged. The next IN retransmits the same data with the same PID.
- Report buffer:
  - report_ready=1 in IDLE, SKIP, TOK*, NAK; 0 from TXPID through WAITHS.
  - report_valid && report_ready loads the buffer and sets pending=1.
  - A reload while pending overwrites the old report; toggle is unaffected.
  - report_valid while report_ready=0 is dropped.
- Latency: first tx byte is valid the cycle after the token's rx_eop.
- Reset mid-packet: immediate return to reset values; toggle returns to DATA0.

Optional Feature:
USBD_CRC5_CHECK_EN
- Defined: the token CRC5 (poly 0x05, init 0x1F, complemented, over the 11 addr+endp bits) is checked at TOKEOP. A bad CRC5 is treated as a mismatch: no response.
- Undefined: the CRC5 field is ignored and matching uses address and endpoint only.

Decomposition:
- Package usbd_pkg holds:
  - PID constants.
  - State enum.
  - CRC16/CRC5 init and residual constants.
  - CRC5 function.
- Sub-module usbd_crc16: byte-wide combinational-next CRC register with clear and enable inputs, reused later by a host-side transmitter.

Test Plan:
- report_valid with "123456789" (C_report_bytes=9), dev_addr=5, IN token to addr 5, ep 1 -> tx bytes C3,31..39,C8,B4 with tx_last on B4; host ACK -> report_sent pulse, toggle=1.
- Second report, second IN -> PID 0x4B; ACK -> toggle=0.
- IN with no pending report -> single byte 5A with tx_last=1; toggle unchanged.
- IN answered, no ACK for C_hs_timeout cycles -> next IN resends identical PID and data; tx_ready held low 3 cycles mid-packet -> tx_data stable throughout.
- IN to addr 6 or ep 2, or rx_err mid-token -> no tx_valid. With USBD_CRC5_CHECK_EN, flipping one CRC5 bit -> no response.
- report_valid during TXDATA -> dropped and buffer unchanged; resetn low during TXDATA -> tx_valid=0, toggle=0 asynchronously.
